// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter that shares one W-bit valid/ready channel between four requesters.
// state | meaning
// IDLE  | no grant held; arbitrate among req starting after ptr
// GRANT | requester sel owns the channel until last, burst cap or withdrawal
module rr_mux_arbiter_4 #(
    parameter int BURST_LEN = 4,
    parameter int W         = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [3:0]   last,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       beat;
    logic       at_cap;
    logic       release_now;

    // Search ptr+1, ptr+2, ptr+3, ptr so the last owner gets lowest priority.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    genvar b;
    generate
        for (b = 0; b < W; b++) begin : g_bit
            logic [3:0] col;
            assign col  = {i3[b], i2[b], i1[b], i0[b]};
            assign y[b] = col[sel];
        end
    endgenerate

    assign y_valid     = (state == GRANT) & req[sel];
    assign beat        = y_valid & y_ready;
    assign at_cap      = ({1'b0, cnt} + 5'd1) == 5'(BURST_LEN);
    assign release_now = (state == GRANT) & ((beat & (last[sel] | at_cap)) | ~req[sel]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd3;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        sel   <= win;
                        gnt   <= 4'b0001 << win;
                        cnt   <= 4'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        ptr   <= sel;
                        cnt   <= 4'd0;
                    end else if (beat) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: two instances (burst cap 4 and 1) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_rr_mux_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] i0, i1, i2, i3;
    logic       y_ready;

    logic [3:0] gnt0, gnt1;
    logic [1:0] sel0, sel1;
    logic [3:0] y0, y1;
    logic       v0, v1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    rr_mux_arbiter_4 #(.BURST_LEN(4), .W(4)) u0 (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .gnt(gnt0), .sel(sel0), .y(y0), .y_valid(v0), .y_ready(y_ready)
    );

    rr_mux_arbiter_4 #(.BURST_LEN(1), .W(4)) u1 (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .gnt(gnt1), .sel(sel1), .y(y1), .y_valid(v1), .y_ready(y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level model: who owns the channel, who owned it last, beats delivered.
    bit m_busy  [2];
    int m_owner [2];
    int m_prev  [2];
    int m_beats [2];

    function automatic int cap_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    function automatic int data_of(input int s);
        case (s)
            0: return int'(i0);
            1: return int'(i1);
            2: return int'(i2);
            default: return int'(i3);
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d]  <= 1'b0;
                m_owner[d] <= 0;
                m_prev[d]  <= 3;
                m_beats[d] <= 0;
            end else if (!m_busy[d]) begin
                if (req != 4'b0000) begin
                    m_busy[d]  <= 1'b1;
                    m_owner[d] <= pick(req, m_prev[d]);
                    m_beats[d] <= 0;
                end
            end else if (!req[m_owner[d]]) begin
                m_busy[d] <= 1'b0;
                m_prev[d] <= m_owner[d];
            end else if (y_ready) begin
                if (last[m_owner[d]] || (m_beats[d] + 1 == cap_of(d))) begin
                    m_busy[d]  <= 1'b0;
                    m_prev[d]  <= m_owner[d];
                    m_beats[d] <= 0;
                end else begin
                    m_beats[d] <= m_beats[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("u0.gnt", int'(gnt0), m_busy[0] ? (1 << m_owner[0]) : 0);
            chk("u0.sel", int'(sel0), m_owner[0]);
            chk("u0.y", int'(y0), data_of(m_owner[0]));
            chk("u0.y_valid", int'(v0), int'(m_busy[0] && req[m_owner[0]]));
            chk("u1.gnt", int'(gnt1), m_busy[1] ? (1 << m_owner[1]) : 0);
            chk("u1.sel", int'(sel1), m_owner[1]);
            chk("u1.y", int'(y1), data_of(m_owner[1]));
            chk("u1.y_valid", int'(v1), int'(m_busy[1] && req[m_owner[1]]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        last = 4'b0000;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1; req = 4'b0000; last = 4'b0000; y_ready = 1'b1;
        i0 = 4'h3; i1 = 4'h0; i2 = 4'h0; i3 = 4'h0;
        cyc();
        cmp_en = 1'b1;
        cyc();

        // Single requester, last on beat 2
        rst = 1'b0; req = 4'b0100; i2 = 4'hA;
        @(negedge clk);
        chk("reset.gnt", int'(gnt0), 0);
        chk("reset.sel", int'(sel0), 0);
        chk("reset.y_valid", int'(v0), 0);
        chk("reset.y", int'(y0), 3);
        cyc();
        @(negedge clk);
        chk("single.gnt", int'(gnt0), 4);
        chk("single.sel", int'(sel0), 2);
        chk("single.y", int'(y0), 10);
        chk("single.v1", int'(v0), 1);
        cyc();
        last = 4'b0100;
        @(negedge clk);
        chk("single.v2", int'(v0), 1);
        chk("single.y2", int'(y0), 10);
        cyc();
        req = 4'b0000; last = 4'b0000;
        @(negedge clk);
        chk("single.rel_gnt", int'(gnt0), 0);
        chk("single.rel_v", int'(v0), 0);

        // Full contention: 4 grant cycles then one bubble, order 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < 25; j++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("cont.gnt[%0d]", j), int'(gnt0), (j % 5 == 4) ? 0 : (1 << ((j / 5) % 4)));
        end

        // Backpressure on requester 1
        do_reset();
        req = 4'b0010; i1 = 4'h5; y_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cyc();
            @(negedge clk);
            chk("bp.v", int'(v0), 1);
            chk("bp.y", int'(y0), 5);
            chk("bp.gnt", int'(gnt0), 2);
        end
        y_ready = 1'b1;
        for (int j = 0; j < 3; j++) cyc();
        @(negedge clk);
        chk("bp.still_granted", int'(gnt0), 2);
        cyc();
        @(negedge clk);
        chk("bp.released", int'(gnt0), 0);

        // Withdrawal of requester 3 after one beat
        do_reset();
        req = 4'b1000;
        cyc();
        req = 4'b1001;
        @(negedge clk);
        chk("wd.gnt3", int'(gnt0), 8);
        cyc();
        req = 4'b0001;
        @(negedge clk);
        chk("wd.v_drop", int'(v0), 0);
        chk("wd.gnt_hold", int'(gnt0), 8);
        cyc();
        @(negedge clk);
        chk("wd.bubble", int'(gnt0), 0);
        cyc();
        @(negedge clk);
        chk("wd.gnt0", int'(gnt0), 1);

        // Reset during the second beat of a requester-2 grant
        do_reset();
        req = 4'b0100; i2 = 4'h9;
        cyc();
        cyc();
        rst = 1'b1; req = 4'b1111;
        @(negedge clk);
        chk("rmb.v_before", int'(v0), 1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rmb.gnt", int'(gnt0), 0);
        chk("rmb.v", int'(v0), 0);
        chk("rmb.sel", int'(sel0), 0);
        cyc();
        @(negedge clk);
        chk("rmb.first", int'(gnt0), 1);

        // Burst cap of 1: alternate 0,1 with a bubble between grants
        do_reset();
        req = 4'b0011;
        for (int j = 0; j < 8; j++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("cap1.gnt[%0d]", j), int'(gnt1), (j % 2 == 1) ? 0 : ((j % 4 == 0) ? 1 : 2));
            chk($sformatf("cap1.v[%0d]", j), int'(v1), (j % 2 == 0) ? 1 : 0);
        end

        // Mixed directed sequence checked by the model only
        do_reset();
        for (int c = 0; c < 60; c++) begin
            cyc();
            req     = 4'((c * 5 + 3) % 16);
            last    = 4'((c * 3) % 16) & 4'b0101;
            y_ready = (c % 3) != 0;
            i0 = 4'(c); i1 = 4'(c + 1); i2 = 4'(c + 2); i3 = 4'(c + 3);
        end
        cyc();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
